// File: rtl/sensor_clock_generator.sv
// Linear image sensor readout clock generator.
// Issues one phi_p reset pulse followed by a burst of phi_l2 shift clocks per line.
module sensor_clock_generator #(
  parameter int HALF_PERIOD  = 2,
  parameter int PIXELS       = 8,
  parameter int PHI_P_CYCLES = 3,
  parameter int GAP_CYCLES   = 2,
  parameter int IDX_W        = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enable,
  input  logic             i_start,
  input  logic             i_continuous,
  output logic             o_phi_p,
  output logic             o_phi_l2,
  output logic [IDX_W-1:0] o_pixel_index,
  output logic             o_line_busy,
  output logic             o_line_done
);

  localparam int PERIOD  = 2 * HALF_PERIOD;
  localparam int MAX_PG  = (PHI_P_CYCLES > GAP_CYCLES) ? PHI_P_CYCLES : GAP_CYCLES;
  localparam int MAX_CNT = (MAX_PG > PERIOD) ? MAX_PG : PERIOD;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t PHI_P_LAST  = cnt_t'(PHI_P_CYCLES - 1);
  localparam cnt_t GAP_LAST    = cnt_t'(GAP_CYCLES - 1);
  localparam cnt_t HALF_LAST   = cnt_t'(HALF_PERIOD - 1);
  localparam cnt_t PERIOD_LAST = cnt_t'(PERIOD - 1);
  localparam logic [IDX_W-1:0] PIX_LAST = IDX_W'(PIXELS);

  typedef enum logic [2:0] {
    IDLE,
    PHI_P,
    GAP,
    SHIFT,
    DONE
  } state_t;

  state_t state;
  cnt_t   cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      cnt           <= '0;
      o_phi_p       <= 1'b0;
      o_phi_l2      <= 1'b1;
      o_pixel_index <= '0;
      o_line_busy   <= 1'b0;
      o_line_done   <= 1'b0;
    end else begin
      o_line_done <= 1'b0;
      // Dropping enable abandons the line; the pixel index is left as a record of progress.
      if (!i_enable && state != IDLE) begin
        state       <= IDLE;
        cnt         <= '0;
        o_phi_p     <= 1'b0;
        o_phi_l2    <= 1'b1;
        o_line_busy <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (i_enable && i_start) begin
              state         <= PHI_P;
              cnt           <= '0;
              o_phi_p       <= 1'b1;
              o_line_busy   <= 1'b1;
              o_pixel_index <= '0;
            end
          end
          PHI_P: begin
            if (cnt == PHI_P_LAST) begin
              state   <= GAP;
              cnt     <= '0;
              o_phi_p <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          GAP: begin
            if (cnt == GAP_LAST) begin
              state         <= SHIFT;
              cnt           <= '0;
              o_phi_l2      <= 1'b0;
              o_pixel_index <= o_pixel_index + 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          SHIFT: begin
            // cnt is the position within the current pixel period; phi_l2 is low for the first half.
            if (cnt == PERIOD_LAST) begin
              cnt <= '0;
              if (o_pixel_index == PIX_LAST) begin
                state       <= DONE;
                o_line_done <= 1'b1;
                o_line_busy <= 1'b0;
                o_phi_l2    <= 1'b1;
              end else begin
                o_phi_l2      <= 1'b0;
                o_pixel_index <= o_pixel_index + 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
              if (cnt == HALF_LAST) begin
                o_phi_l2 <= 1'b1;
              end
            end
          end
          DONE: begin
            if (i_enable && i_continuous) begin
              state         <= PHI_P;
              cnt           <= '0;
              o_phi_p       <= 1'b1;
              o_line_busy   <= 1'b1;
              o_pixel_index <= '0;
            end else begin
              state <= IDLE;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sensor_clock_generator.sv
// Scoreboard bench for sensor_clock_generator: expected per-cycle output traces are
// queued when a line is requested and compared cycle by cycle as the DUT runs.
module tb_sensor_clock_generator;

  localparam int HP   = 2;
  localparam int PIX  = 8;
  localparam int PP   = 3;
  localparam int GP   = 2;
  localparam int IW   = 8;
  localparam int PER  = 2 * HP;
  localparam int LINE = PP + GP + PIX * PER;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          start = 1'b0;
  logic          cont = 1'b0;
  logic          phi_p;
  logic          phi_l2;
  logic [IW-1:0] pixel_index;
  logic          line_busy;
  logic          line_done;

  sensor_clock_generator #(
    .HALF_PERIOD (HP),
    .PIXELS      (PIX),
    .PHI_P_CYCLES(PP),
    .GAP_CYCLES  (GP),
    .IDX_W       (IW)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_enable     (enable),
    .i_start      (start),
    .i_continuous (cont),
    .o_phi_p      (phi_p),
    .o_phi_l2     (phi_l2),
    .o_pixel_index(pixel_index),
    .o_line_busy  (line_busy),
    .o_line_done  (line_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int             cyc;
    logic [IW+3:0]  v;
    string          tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Output vector layout: {phi_p, phi_l2, busy, done, pixel_index}
  function automatic logic [IW+3:0] line_vec(input int k);
    int j;
    if (k < PP) return {4'b1110, IW'(0)};
    if (k < PP + GP) return {4'b0110, IW'(0)};
    if (k < LINE) begin
      j = k - PP - GP;
      return {1'b0, ((j % PER) >= HP), 2'b10, IW'(j / PER + 1)};
    end
    return {4'b0101, IW'(PIX)};
  endfunction

  function automatic logic [IW+3:0] idle_vec(input int idx);
    return {4'b0100, IW'(idx)};
  endfunction

  task automatic push(input int c, input logic [IW+3:0] v, input string tag);
    exp_t e;
    e.cyc = c;
    e.v   = v;
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic push_line(input int s, input int n, input string tag);
    for (int k = 0; k < n && k <= LINE; k++) push(s + k, line_vec(k), tag);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.cyc < cyc) check({e.tag, "_stale"}, 64'(cyc), 64'(e.cyc));
      else check(e.tag, 64'({phi_p, phi_l2, line_busy, line_done, pixel_index}), 64'(e.v));
    end
  end

  // Downstream ADC trigger stand-in: one start on the 5th phi_l2 fall after phi_p.
  int adc_falls = 0;
  int adc_starts = 0;
  logic prev_l2 = 1'b1;
  always @(negedge clk) begin
    prev_l2 <= phi_l2;
    if (phi_p) adc_falls <= 0;
    else if (prev_l2 && !phi_l2) begin
      adc_falls <= adc_falls + 1;
      if (adc_falls == 4) adc_starts <= adc_starts + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got timeout expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int adc0;
    step(3);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) push(cyc + i, idle_vec(0), "reset");
    step(3);

    // Single line with defaults
    enable = 1'b1;
    start  = 1'b1;
    s = cyc + 1;
    push_line(s, LINE + 1, "line1");
    for (int i = 1; i <= 3; i++) push(s + LINE + i, idle_vec(PIX), "line1_idle");
    step(1);
    start = 1'b0;
    step(LINE + 5);

    // Start requests during a line are ignored
    start = 1'b1;
    s = cyc + 1;
    push_line(s, LINE + 1, "ign");
    for (int i = 1; i <= 4; i++) push(s + LINE + i, idle_vec(PIX), "ign_idle");
    step(1);
    start = 1'b0;
    step(3);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(14);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(24);

    // Enable dropped after the third phi_l2 fall
    start = 1'b1;
    s = cyc + 1;
    push_line(s, PP + GP + 2 * PER + 2, "abort");
    for (int i = 15; i <= 17; i++) push(s + i, idle_vec(3), "abort_idle");
    step(1);
    start = 1'b0;
    step(14);
    enable = 1'b0;
    step(4);
    enable = 1'b1;
    step(2);

    // Reset in the middle of SHIFT
    start = 1'b1;
    s = cyc + 1;
    push_line(s, 8, "rstmid");
    push(s + 8, idle_vec(0), "rstmid_reset");
    push(s + 9, idle_vec(0), "rstmid_idle");
    step(1);
    start = 1'b0;
    step(7);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(2);

    // Full line after the reset
    start = 1'b1;
    s = cyc + 1;
    push_line(s, LINE + 1, "post_rst");
    for (int i = 1; i <= 2; i++) push(s + LINE + i, idle_vec(PIX), "post_rst_idle");
    step(1);
    start = 1'b0;
    step(LINE + 3);

    // Three back-to-back lines in continuous mode
    adc0  = adc_starts;
    cont  = 1'b1;
    start = 1'b1;
    s = cyc + 1;
    for (int l = 0; l < 3; l++) push_line(s + l * (LINE + 1), LINE + 1, "cont");
    for (int i = 0; i < 3; i++) push(s + 3 * (LINE + 1) + i, idle_vec(PIX), "cont_idle");
    step(1);
    start = 1'b0;
    step(2 * (LINE + 1) + 3);
    cont = 1'b0;
    step(LINE + 5);
    check("adc_starts", 64'(adc_starts - adc0), 64'(3));

    for (int i = 0; i < 10 && q.size() > 0; i++) step(1);
    if (q.size() != 0) check("queue_drain", 64'(q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sensor_clock_generator.md
Name: sensor_clock_generator

Overview:
Generates the linear image sensor readout clocks: a pixel reset pulse `o_phi_p` followed by a burst of pixel shift clocks `o_phi_l2`, one burst per line. It sits upstream of the ADC trigger logic, which counts falling edges of `phi_l2` after `phi_p` to time ADC start-of-conversion. All timing is derived from the single system clock by counters. Lines are issued on a start request or back-to-back in continuous mode.

Parameters:
- `HALF_PERIOD`, 2: `i_clk` cycles per `phi_l2` half period; must be ≥ 1.
- `PIXELS`, 8: `phi_l2` periods (falling edges) per line; must be ≥ 1.
- `PHI_P_CYCLES`, 3: `i_clk` cycles `o_phi_p` is held high; must be ≥ 1.
- `GAP_CYCLES`, 2: `i_clk` cycles between `phi_p` falling and the first `phi_l2` falling; must be ≥ 1.
- `IDX_W`, 8: width of `o_pixel_index`; must satisfy 2^`IDX_W` > `PIXELS`.

Ports:
- `i_clk`, input, 1: system clock; all logic on its rising edge.
- `i_rst`, input, 1: synchronous active-high reset.
- `i_enable`, input, 1: block enable; low aborts any line in progress.
- `i_start`, input, 1: line request, sampled in IDLE only.
- `i_continuous`, input, 1: when high, the next line starts automatically after DONE.
- `o_phi_p`, output, 1: pixel reset pulse, active high.
- `o_phi_l2`, output, 1: pixel shift clock; idles high.
- `o_pixel_index`, output, `IDX_W`: count of `phi_l2` falling edges issued in the current line.
- `o_line_busy`, output, 1: high from the first PHI_P cycle through the last SHIFT cycle.
- `o_line_done`, output, 1: one-cycle pulse after a line completes normally.

Behaviour:
- All outputs are registered (no combinational paths from inputs to outputs).
- Reset values: `o_phi_p`=0, `o_phi_l2`=1, `o_pixel_index`=0, `o_line_busy`=0, `o_line_done`=0; state=IDLE; all counters 0.
- State machine: IDLE, PHI_P, GAP, SHIFT, DONE.
- IDLE:
  - Outputs at idle levels.
  - When `i_enable`=1 and `i_start`=1 at a clock edge, the next cycle is PHI_P, with `o_phi_p`=1 and `o_line_busy`=1.
  - Latency from the `i_start` sample to `phi_p` high is 1 cycle.
- PHI_P:
  - `o_phi_p`=1 and `o_phi_l2`=1 for exactly `PHI_P_CYCLES` cycles.
  - `o_pixel_index` is cleared to 0 on entry.
  - Then GAP.
- GAP:
  - `o_phi_p`=0 and `o_phi_l2`=1 for exactly `GAP_CYCLES` cycles.
  - Then SHIFT.
- SHIFT:
  - Each pixel period is `2*HALF_PERIOD` cycles: `o_phi_l2`=0 for `HALF_PERIOD` cycles, then 1 for `HALF_PERIOD` cycles.
  - `o_phi_l2` falls on the first cycle of each period.
  - `o_pixel_index` increments in the same cycle `o_phi_l2` falls, so it reads 1 in pixel 1 and `PIXELS` in the last pixel.
  - After `PIXELS` complete periods, go to DONE. `o_phi_l2` is high in the last SHIFT cycle.
- DONE:
  - One cycle with `o_line_done`=1, `o_line_busy`=0, `o_phi_l2`=1, and `o_pixel_index` holding `PIXELS`.
  - Next state is PHI_P if `i_enable`=1 and `i_continuous`=1; otherwise IDLE.
  - `i_start` is not required for a continuous restart.
- `i_start` outside IDLE is ignored; no request is queued.
- `i_enable`=0 in any non-IDLE state:
  - The next cycle is IDLE with idle output levels.
  - `o_pixel_index` holds its value.
  - No `o_line_done` pulse is issued.
- `i_rst` mid-line: same as the reset values above; `i_rst` has priority over all inputs.
- Counter widths are sized for the largest parameter value; no wrap-around occurs for legal parameters.
- `o_phi_p` and `o_phi_l2` are never both low-to-high or high-to-low in the same cycle.
- `o_phi_l2` never falls while `o_phi_p`=1.

Test Plan:
- Reset then single line (defaults), `i_start` high at cycle 0 → `o_phi_p`=1 in cycles 1–3; GAP in cycles 4–5; `o_phi_l2` falls at cycles 6,10,…,34 (8 falls); `o_pixel_index` reaches 8 at cycle 34; `o_line_done`=1 only at cycle 38; `o_line_busy`=1 in cycles 1–37.
- Continuous mode with `i_continuous`=1 held → after DONE at cycle 38, `o_phi_p` rises at cycle 39; two consecutive lines are identical, and `o_pixel_index` restarts at 0 then 1 at the first fall.
- `i_start` pulsed at cycles 5 and 20 during a line → no effect; exactly one `o_line_done`; next line only on a later `i_start` in IDLE.
- `i_enable` dropped at cycle 15 (SHIFT, after the 3rd fall) → cycle 16 shows IDLE levels (`phi_l2`=1, `phi_p`=0, busy=0); `o_pixel_index` holds 3; no done pulse.
- `i_rst` asserted at cycle 8 during SHIFT → next cycle all outputs at reset values; a subsequent `i_start` yields a full normal line.
- Pairing with the ADC trigger block (enable high) → exactly one ADC start per line, following the 5th `phi_l2` falling edge; checked over 3 continuous lines.
